// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave.
// Two-stage pipeline: capture {cmd,payload}, then execute against memory.
module spi_ram_ctrl #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int AUTO_INC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              addr_err,
   output logic              rd_ovf
);

   localparam logic [1:0] CMD_SET_WA = 2'b00;
   localparam logic [1:0] CMD_WRITE  = 2'b01;
   localparam logic [1:0] CMD_SET_RA = 2'b10;
   localparam logic [1:0] CMD_READ   = 2'b11;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W+1:0] cmd_q, cmd_d;
   logic              cmd_v_q, cmd_v_d;
   logic [ADDR_W-1:0] write_addr_q, write_addr_d;
   logic [ADDR_W-1:0] read_addr_q, read_addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              tx_valid_q, tx_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              rd_ovf_q, rd_ovf_d;

   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [1:0]        op;
   logic [DATA_W-1:0] pay;
   logic              in_range;
   logic              slot_free;
   logic              mem_we;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   assign op       = cmd_q[DATA_W+1:DATA_W];
   assign pay      = cmd_q[DATA_W-1:0];
   assign in_range = 32'(pay) < 32'(DEPTH);

   always_comb begin
      cmd_d        = rx_valid ? din : cmd_q;
      cmd_v_d      = rx_valid;
      write_addr_d = write_addr_q;
      read_addr_d  = read_addr_q;
      dout_d       = dout_q;
      // An accepted word frees the slot; a read below may refill it at once.
      tx_valid_d   = tx_valid_q && !tx_ready;
      slot_free    = !tx_valid_q || tx_ready;
      addr_err_d   = 1'b0;
      rd_ovf_d     = 1'b0;
      mem_we       = 1'b0;
      if (cmd_v_q) begin
         unique case (op)
            CMD_SET_WA: begin
               if (in_range) write_addr_d = pay[ADDR_W-1:0];
               else          addr_err_d   = 1'b1;
            end
            CMD_WRITE: begin
               mem_we = 1'b1;
               if (AUTO_INC != 0) write_addr_d = next_addr(write_addr_q);
            end
            CMD_SET_RA: begin
               if (in_range) read_addr_d = pay[ADDR_W-1:0];
               else          addr_err_d  = 1'b1;
            end
            CMD_READ: begin
               if (slot_free) begin
                  dout_d     = mem[read_addr_q];
                  tx_valid_d = 1'b1;
                  if (AUTO_INC != 0) read_addr_d = next_addr(read_addr_q);
               end else begin
                  rd_ovf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q        <= '0;
         cmd_v_q      <= 1'b0;
         write_addr_q <= '0;
         read_addr_q  <= '0;
         dout_q       <= '0;
         tx_valid_q   <= 1'b0;
         addr_err_q   <= 1'b0;
         rd_ovf_q     <= 1'b0;
      end else begin
         cmd_q        <= cmd_d;
         cmd_v_q      <= cmd_v_d;
         write_addr_q <= write_addr_d;
         read_addr_q  <= read_addr_d;
         dout_q       <= dout_d;
         tx_valid_q   <= tx_valid_d;
         addr_err_q   <= addr_err_d;
         rd_ovf_q     <= rd_ovf_d;
      end
   end

   // Storage is deliberately unreset; cmd_v_q gates writes during reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[write_addr_q] <= pay;
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign addr_err = addr_err_q;
   assign rd_ovf   = rd_ovf_q;

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command-decoding single-port memory behind the SPI slave. Consumes {cmd[1:0], payload} words from the SPI receive path and returns read data to the SPI transmit path.
- Parametrised successor of the fixed 8-bit/10-word command RAM. Adds parametrised width and depth, optional address auto-increment for burst transfers, and a tx_valid/tx_ready handshake with overflow reporting.
- Address range checking is also new.

Parameters:
- DATA_W, 8, memory word width and payload width.
- ADDR_W, 8, address register width; must be <= DATA_W. Addresses are taken from payload[ADDR_W-1:0].
- DEPTH, 256, number of memory words; must be <= 2**ADDR_W.
- AUTO_INC, 1, when 1 the write/read address increments after each data write/read; when 0 the address holds.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_W+2  command word: din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload.
- rx_valid  in  1  din valid this cycle; single-cycle qualifier.
- tx_ready  in  1  SPI transmit side accepts dout this cycle.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until accepted.
- addr_err  out  1  one-cycle pulse when a set-address payload is >= DEPTH.
- rd_ovf  out  1  one-cycle pulse when a read command is dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write_addr, read_addr, cmd_q, cmd_v clear to 0.
  - dout, tx_valid, addr_err and rd_ovf clear to 0.
  - Memory contents are not reset and are undefined after power-up.
- Two-stage pipeline:
  - Edge N: when rx_valid=1, din is captured into cmd_q and cmd_v is set to 1. When rx_valid=0, cmd_v is set to 0.
  - Edge N+1: the command in cmd_q executes if cmd_v=1.
  - One command per cycle, back-to-back supported. No backpressure on rx.
- Command decode at execute:
  - cmd 00 (set write addr): if payload < DEPTH, write_addr <= payload[ADDR_W-1:0]. Otherwise write_addr is unchanged and addr_err pulses.
  - cmd 01 (write data): mem[write_addr] <= payload. If AUTO_INC=1, write_addr <= (write_addr == DEPTH-1) ? 0 : write_addr + 1.
  - cmd 10 (set read addr): same range rule as cmd 00, applied to read_addr.
  - cmd 11 (read): payload is ignored.
    - If the output slot is free, dout <= mem[read_addr], tx_valid <= 1, and read_addr auto-increments with the same wrap rule as writes.
    - Otherwise the command is dropped: rd_ovf pulses, and read_addr and dout are unchanged.
- Read latency: tx_valid rises at edge N+1 for a read command sampled at edge N, i.e. 2 cycles after rx_valid is asserted.
- Output slot is free when tx_valid=0, or when tx_valid=1 and tx_ready=1 in the same cycle (a transfer and a new load in the same cycle).
- Handshake:
  - A transfer occurs on a rising edge where tx_valid and tx_ready are both 1.
  - After a transfer with no new load in that cycle, tx_valid <= 0.
  - dout is stable while tx_valid=1 and no transfer occurs.
  - dout holds its last value after tx_valid falls.
- Hazards:
  - A write executing at edge M followed by a read of the same address executing at edge M+1 returns the new data.
  - Write and read addresses are independent.
  - A set-read-address and a read cannot coincide, since only one command executes per cycle.
- Pulse timing: addr_err and rd_ovf are asserted for exactly the cycle after the offending command executes. They are registered and never held.
- Reset mid-burst: all state clears. A pending tx_valid is lost, and any in-flight cmd_q command is discarded without a memory write.

Test Plan:
- DATA_W=8, DEPTH=256, AUTO_INC=1, tx_ready=1:
  - Stimulus: {00,0x10}, {01,0xA5}, {01,0x5A}, {10,0x10}, {11,x}, {11,x}.
  - Response: dout 0xA5 then 0x5A, each with a one-cycle tx_valid pulse, 2 cycles after the respective read command.
- Wrap: set write addr 0xFF, write 0x11, 0x22; set read addr 0xFF, read twice -> 0x11, then 0x22 (from address 0x00).
- DEPTH=200:
  - Stimulus: {00,0xC8}.
  - Response: addr_err pulses one cycle; write_addr retains its prior value, so the next write lands at the old address.
- tx_ready=0:
  - Stimulus: two back-to-back reads.
  - Response: first read data is held on dout with tx_valid=1; second read is dropped with a rd_ovf pulse and read_addr advanced only once.
  - Then: raise tx_ready -> tx_valid falls after one transfer.
- AUTO_INC=0: write 0x33 then 0x44 at address 5, read twice -> 0x44 both times.
- Reset: assert rst_n low while tx_valid=1 mid-burst -> dout=0, tx_valid=0 immediately (asynchronous); after release, address registers read back as 0.
